// File: rtl/pocket_audio_mix_sched.sv
// rtl/pocket_audio_mix_sched.sv - 48 kHz sample scheduler and volume mixer feeding the I2S serializer
// Optional POCKET_MIX_CLIPCNT_EN adds an 8-bit saturating CLIP_CNT output.
module pocket_audio_mix_sched #(
  parameter int NCH      = 4,
  parameter int BITS     = 16,
  parameter int VOL_BITS = 4,
  parameter int CLK_HZ   = 74250000,
  parameter int RATE_HZ  = 48000
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic [NCH-1:0]           CH_REQ,
  input  logic [NCH*BITS-1:0]      CH_DATA,
  output logic [NCH-1:0]           CH_ACK,
  input  logic [NCH*VOL_BITS-1:0]  CH_VOL,
  input  logic                     MUTE,
  output logic signed [BITS-1:0]   AUDIO_OUT,
  output logic                     SAMPLE_STB,
`ifdef POCKET_MIX_CLIPCNT_EN
  output logic [7:0]               CLIP_CNT,
`endif
  output logic                     OVERRUN
);

  localparam int ACC_W = $clog2(CLK_HZ + RATE_HZ);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W = BITS + VOL_BITS + $clog2(NCH) + 1;
  localparam logic [ACC_W-1:0] RATE_C = ACC_W'(RATE_HZ);
  localparam logic [ACC_W-1:0] CLK_C  = ACC_W'(CLK_HZ);
  localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, SCAN, MIX, OUT} state_t;

  state_t                      state;
  state_t                      state_n;
  logic [ACC_W-1:0]            acc;
  logic [ACC_W-1:0]            nxt;
  logic                        tick;
  logic                        pending;
  logic [IDX_W-1:0]            idx;
  logic                        last;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     shifted;
  logic signed [BITS-1:0]      clamped;
  logic signed [VOL_BITS:0]    vol_s;
  logic signed [BITS+VOL_BITS:0] prod;
  logic signed [BITS-1:0]      hold [NCH];

  // Acc always stays below CLK_HZ, so acc + RATE_HZ fits in ACC_W bits.
  assign nxt  = acc + RATE_C;
  assign tick = (nxt >= CLK_C);
  assign last = (idx == IDX_W'(NCH - 1));

  assign vol_s   = signed'({1'b0, CH_VOL[idx*VOL_BITS +: VOL_BITS]});
  assign prod    = hold[idx] * vol_s;
  assign shifted = sum >>> (VOL_BITS - 1);

  always_comb begin
    clamped = shifted[BITS-1:0];
    if (shifted > SAT_HI) begin
      clamped = SAT_HI[BITS-1:0];
    end else if (shifted < SAT_LO) begin
      clamped = SAT_LO[BITS-1:0];
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    CH_ACK  = '0;
    case (state)
      IDLE: if (tick || pending) state_n = SCAN;
      SCAN: begin
        CH_ACK[idx] = CH_REQ[idx];
        if (last) state_n = MIX;
      end
      MIX:  if (last) state_n = OUT;
      OUT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      acc        <= '0;
      pending    <= 1'b0;
      OVERRUN    <= 1'b0;
      idx        <= '0;
      sum        <= '0;
      AUDIO_OUT  <= '0;
      SAMPLE_STB <= 1'b0;
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
`ifdef POCKET_MIX_CLIPCNT_EN
      CLIP_CNT   <= 8'd0;
`endif
    end else begin
      acc        <= tick ? (nxt - CLK_C) : nxt;
      SAMPLE_STB <= 1'b0;
      // A tick that lands mid-frame is remembered; a second one is lost.
      if (tick && state != IDLE) begin
        pending <= 1'b1;
        if (pending) OVERRUN <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick || pending) begin
            idx     <= '0;
            sum     <= '0;
            pending <= tick && pending;
          end
        end
        SCAN: begin
          if (CH_REQ[idx]) hold[idx] <= CH_DATA[idx*BITS +: BITS];
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        MIX: begin
          sum <= sum + SUM_W'(prod);
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        OUT: begin
          AUDIO_OUT  <= MUTE ? '0 : clamped;
          SAMPLE_STB <= 1'b1;
`ifdef POCKET_MIX_CLIPCNT_EN
          if ((shifted > SAT_HI || shifted < SAT_LO) && CLIP_CNT != 8'hFF)
            CLIP_CNT <= CLIP_CNT + 8'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pocket_audio_mix_sched.sv
// tb/tb_pocket_audio_mix_sched.sv - randomized self-checking bench for pocket_audio_mix_sched
module tb_pocket_audio_mix_sched;

  logic               iCLK = 1'b0;
  logic               iRST_N;
  logic [3:0]         CH_REQ;
  logic [63:0]        CH_DATA;
  logic [3:0]         CH_ACK;
  logic [15:0]        CH_VOL;
  logic               MUTE;
  logic signed [15:0] AUDIO_OUT;
  logic               SAMPLE_STB;
  logic               OVERRUN;
`ifdef POCKET_MIX_CLIPCNT_EN
  logic [7:0]         CLIP_CNT;
  logic [7:0]         f_clip;
`endif

  logic [3:0]         f_ack;
  logic signed [15:0] f_audio;
  logic               f_stb;
  logic               f_overrun;

  int errors = 0;
  int checks = 0;

  int         m_hold [4];
  int         ack_ch [$];
  int         ack_at [$];
  bit         ack_multi;
  logic [3:0] ack_mask;

  always #5 iCLK = ~iCLK;

  pocket_audio_mix_sched dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .CH_REQ(CH_REQ), .CH_DATA(CH_DATA), .CH_ACK(CH_ACK),
    .CH_VOL(CH_VOL), .MUTE(MUTE), .AUDIO_OUT(AUDIO_OUT), .SAMPLE_STB(SAMPLE_STB),
`ifdef POCKET_MIX_CLIPCNT_EN
    .CLIP_CNT(CLIP_CNT),
`endif
    .OVERRUN(OVERRUN)
  );

  // Tiny clock ratio so ticks arrive faster than a frame can finish.
  pocket_audio_mix_sched #(.CLK_HZ(12), .RATE_HZ(4)) u_fast (
    .iCLK(iCLK), .iRST_N(iRST_N), .CH_REQ(4'h0), .CH_DATA(64'h0), .CH_ACK(f_ack),
    .CH_VOL(16'h0), .MUTE(1'b0), .AUDIO_OUT(f_audio), .SAMPLE_STB(f_stb),
`ifdef POCKET_MIX_CLIPCNT_EN
    .CLIP_CNT(f_clip),
`endif
    .OVERRUN(f_overrun)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hold[i] = 0;
  endtask

  task automatic model_eval(input logic [3:0] req, input int d[4], input int v[4], input bit mute,
                            output int exp, output bit clipped);
    longint s;
    longint q;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) m_hold[i] = d[i];
      s += longint'(m_hold[i]) * longint'(v[i]);
    end
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q -= 1;
    clipped = 1'b0;
    if (q > 32767) begin exp = 32767; clipped = 1'b1; end
    else if (q < -32768) begin exp = -32768; clipped = 1'b1; end
    else exp = int'(q);
    if (mute) exp = 0;
  endtask

  task automatic apply(input logic [3:0] req, input int d[4], input int v[4], input bit mute,
                       output int exp, output bit clipped);
    CH_REQ = req;
    MUTE   = mute;
    for (int i = 0; i < 4; i++) begin
      CH_DATA[i*16 +: 16] = d[i][15:0];
      CH_VOL[i*4 +: 4]    = v[i][3:0];
    end
    model_eval(req, d, v, mute, exp, clipped);
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    ack_ch.delete();
    ack_at.delete();
    ack_multi = 1'b0;
    ack_mask  = 4'h0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iCLK);
      if ($countones(CH_ACK) > 1) ack_multi = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (CH_ACK[i]) begin
          ack_ch.push_back(i);
          ack_at.push_back(c);
          ack_mask[i] = 1'b1;
        end
      end
      if (SAMPLE_STB) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRST_N  = 1'b0;
    CH_REQ  = 4'h0;
    CH_DATA = '0;
    CH_VOL  = '0;
    MUTE    = 1'b0;
    model_reset();
    repeat (3) @(negedge iCLK);
    checks++;
    if (AUDIO_OUT !== 16'h0 || SAMPLE_STB !== 1'b0 || CH_ACK !== 4'h0 || OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h stb=%b ack=%b ovr=%b want 0000/0/0000/0",
               AUDIO_OUT, SAMPLE_STB, CH_ACK, OVERRUN);
    end
    checks++;
    if (f_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_fast_overrun: got %b want 0", f_overrun);
    end
    iRST_N = 1'b1;
  endtask

  task automatic test_rate();
    bit ok;
    int strobes;
    int last_at;
    int gap;
    wait_strobe(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rate_first_strobe: got none want strobe in 2000"); end
    strobes = 0;
    last_at = 0;
    for (int c = 1; c <= 24750; c++) begin
      @(negedge iCLK);
      if (SAMPLE_STB) begin
        strobes++;
        gap = c - last_at;
        last_at = c;
        checks++;
        if (gap != 1546 && gap != 1547) begin
          errors++;
          $display("FAIL rate_spacing: got %0d want 1546 or 1547", gap);
        end
      end
    end
    checks++;
    if (strobes != 16) begin
      errors++;
      $display("FAIL rate_count: got %0d want 16", strobes);
    end
    checks++;
    if (OVERRUN !== 1'b0) begin errors++; $display("FAIL rate_overrun: got %b want 0", OVERRUN); end
    wait_strobe(2000, ok);
  endtask

  task automatic test_unity();
    int d[4]; int v[4]; int exp; bit clp; bit ok; bit seq_ok;
    d = '{1000, 5555, -7000, 123};
    v = '{8, 0, 0, 0};
    apply(4'hF, d, v, 1'b0, exp, clp);
    wait_strobe(2000, ok);
    checks++;
    if (!ok || AUDIO_OUT !== 16'(exp)) begin
      errors++;
      $display("FAIL unity_out: got %0d want %0d", AUDIO_OUT, exp);
    end
    seq_ok = (ack_ch.size() == 4) && !ack_multi;
    if (seq_ok) for (int i = 0; i < 4; i++) if (ack_ch[i] != i || ack_at[i] != ack_at[0] + i) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL unity_ack_seq: got %0d acks mask=%b multi=%b want 0,1,2,3 consecutive",
               ack_ch.size(), ack_mask, ack_multi);
    end
  endtask

  task automatic test_saturation();
    int d[4]; int v[4]; int exp; bit clp; bit ok;
`ifdef POCKET_MIX_CLIPCNT_EN
    logic [7:0] c0;
`endif
    v = '{8, 8, 8, 8};
    for (int pass = 0; pass < 2; pass++) begin
      d = (pass == 0) ? '{28672, 28672, 28672, 28672} : '{-28672, -28672, -28672, -28672};
`ifdef POCKET_MIX_CLIPCNT_EN
      c0 = CLIP_CNT;
`endif
      apply(4'hF, d, v, 1'b0, exp, clp);
      wait_strobe(2000, ok);
      checks++;
      if (!ok || AUDIO_OUT !== 16'(exp)) begin
        errors++;
        $display("FAIL saturation_out%0d: got %h want %h", pass, AUDIO_OUT, 16'(exp));
      end
`ifdef POCKET_MIX_CLIPCNT_EN
      @(negedge iCLK);
      checks++;
      if (CLIP_CNT !== c0 + 8'd1) begin
        errors++;
        $display("FAIL saturation_clipcnt%0d: got %0d want %0d", pass, CLIP_CNT, c0 + 8'd1);
      end
`endif
    end
  endtask

  task automatic test_stale();
    int d[4]; int v[4]; int exp; bit clp; bit ok;
    v = '{8, 0, 0, 0};
    d = '{-500, 0, 0, 0};
    apply(4'h1, d, v, 1'b0, exp, clp);
    wait_strobe(2000, ok);
    checks++;
    if (!ok || AUDIO_OUT !== 16'(exp)) begin
      errors++;
      $display("FAIL stale_load: got %0d want %0d", AUDIO_OUT, exp);
    end
    d = '{1234, 0, 0, 0};
    apply(4'h0, d, v, 1'b0, exp, clp);
    wait_strobe(2000, ok);
    checks++;
    if (!ok || AUDIO_OUT !== 16'(exp)) begin
      errors++;
      $display("FAIL stale_reuse: got %h want %h", AUDIO_OUT, 16'(exp));
    end
    checks++;
    if (ack_mask !== 4'h0) begin
      errors++;
      $display("FAIL stale_no_ack: got ack mask %b want 0000", ack_mask);
    end
  endtask

  task automatic test_mute_volume();
    int d[4]; int v[4]; int exp; bit clp; bit ok;
    bit mutes[3];
    d = '{2000, 0, 0, 0};
    v = '{4, 0, 0, 0};
    mutes = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      apply(4'hF, d, v, mutes[k], exp, clp);
      wait_strobe(2000, ok);
      checks++;
      if (!ok || AUDIO_OUT !== 16'(exp)) begin
        errors++;
        $display("FAIL mute_vol_out%0d: got %0d want %0d", k, AUDIO_OUT, exp);
      end
      checks++;
      if (ack_mask !== 4'hF || ack_multi) begin
        errors++;
        $display("FAIL mute_vol_acks%0d: got mask %b multi %b want 1111 single", k, ack_mask, ack_multi);
      end
    end
  endtask

  task automatic test_random();
    int d[4]; int v[4]; int exp; bit clp; bit ok; logic [3:0] req; bit mute;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = int'($urandom_range(0, 65535)) - 32768;
        v[i] = int'($urandom_range(0, 15));
      end
      req  = 4'($urandom_range(0, 15));
      mute = ($urandom_range(0, 3) == 0);
      apply(req, d, v, mute, exp, clp);
      wait_strobe(2000, ok);
      checks++;
      if (!ok || AUDIO_OUT !== 16'(exp)) begin
        errors++;
        $display("FAIL random_out%0d: got %0d want %0d", k, AUDIO_OUT, exp);
      end
      checks++;
      if (ack_mask !== req || ack_multi) begin
        errors++;
        $display("FAIL random_acks%0d: got mask %b multi %b want %b", k, ack_mask, ack_multi, req);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int d[4]; int v[4]; int exp; bit clp; bit seen; bit stray; int at;
    d = '{300, 400, 500, 600};
    v = '{8, 0, 0, 0};
    apply(4'hF, d, v, 1'b0, exp, clp);
    seen = 0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge iCLK);
      if (CH_ACK[2]) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midscan_find_idx2: got no ack2 want ack2"); end
    iRST_N = 1'b0;
    @(negedge iCLK);
    checks++;
    if (AUDIO_OUT !== 16'h0 || SAMPLE_STB !== 1'b0 || CH_ACK !== 4'h0 || OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL midscan_reset_outputs: got out=%h stb=%b ack=%b ovr=%b want zeros",
               AUDIO_OUT, SAMPLE_STB, CH_ACK, OVERRUN);
    end
    stray = 0;
    repeat (4) begin
      @(negedge iCLK);
      if (CH_ACK !== 4'h0 || SAMPLE_STB !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL midscan_stray_activity: got ack/strobe want none"); end
    model_reset();
    model_eval(4'hF, d, v, 1'b0, exp, clp);
    iRST_N = 1'b1;
    at = -1;
    for (int c = 1; c <= 3000 && at < 0; c++) begin
      @(negedge iCLK);
      if (SAMPLE_STB) at = c;
    end
    checks++;
    if (at != 1556) begin
      errors++;
      $display("FAIL midscan_first_latency: got %0d want 1556", at);
    end
    checks++;
    if (AUDIO_OUT !== 16'(exp)) begin
      errors++;
      $display("FAIL midscan_first_value: got %0d want %0d", AUDIO_OUT, exp);
    end
  endtask

  task automatic test_overrun();
    int fs;
    fs = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (f_stb) fs++;
    end
    checks++;
    if (f_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", f_overrun);
    end
    checks++;
    if (fs == 0 || f_audio !== 16'h0 || f_ack !== 4'h0) begin
      errors++;
      $display("FAIL overrun_fast_activity: got strobes=%0d out=%h ack=%b want >0/0000/0000",
               fs, f_audio, f_ack);
    end
    checks++;
    if (OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL overrun_main_clear: got %b want 0", OVERRUN);
    end
  endtask

  initial begin
    test_reset();
    test_rate();
    test_unity();
    test_saturation();
    test_stale();
    test_mute_volume();
    test_random();
    test_reset_mid_scan();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
